dcache_dm_wb: RTL

- Parametrised direct-mapped, write-back, write-allocate data cache.
- Sits between the pipelined core's MEM stage and the slow external memory.
- Hits are served in the same cycle. A miss raises proc_stall, which freezes all pipeline registers until the line is filled.
- Generalises the core's single-word memory port to configurable line count, line width and address width, with a mem_ready handshake.

---
 rtl/dcache_dm_wb_if.sv | 37 +++
 rtl/dcache_dm_wb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wb_if.sv
// Bundles the processor-side request port and the memory-side line port of dcache_dm_wb.
// The slave modport is the cache's view; the master modport is the core plus memory environment.
interface dcache_dm_wb_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) ();
    localparam int OFF_W = $clog2(WORDS);

    logic                      proc_read;
    logic                      proc_write;
    logic [ADDR_W-1:0]         proc_addr;
    logic [DATA_W-1:0]         proc_wdata;
    logic [DATA_W-1:0]         proc_rdata;
    logic                      proc_stall;

    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-OFF_W-1:0]   mem_addr;
    logic [DATA_W*WORDS-1:0]   mem_wdata;
    logic [DATA_W*WORDS-1:0]   mem_rdata;
    logic                      mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with same-cycle hits and a line-wide memory handshake.
// Defining DCACHE_STAT_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_dm_wb #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int LINES  = 8,
    parameter int WORDS  = 4
) (
    input  logic               clk,
    input  logic               rst,
    dcache_dm_wb_if.slave      bus
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int OFF_B  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = DATA_W * WORDS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WBACK = 2'd1;
    localparam logic [1:0] ALLOC = 2'd2;

    logic [1:0]              state;
    logic [LINES-1:0]        valid;
    logic [LINES-1:0]        dirty;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [LINE_W-1:0]       data_mem [LINES];

    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic [OFF_B-1:0]        off;
    logic [IDX_W-1:0]        miss_idx;
    logic [TAG_W-1:0]        miss_tag;

    logic                    req;
    logic                    hit;
    logic                    read_hit;
    logic [DATA_W-1:0]       rd_word;
    logic [DATA_W-1:0]       rdata_q;

    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [ADDR_W-OFF_W-1:0] mem_addr_q;
    logic [LINE_W-1:0]       mem_wdata_q;

    generate
        if (OFF_W > 0) begin : g_off
            assign off = bus.proc_addr[OFF_B-1:0];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    assign idx      = bus.proc_addr[OFF_W +: IDX_W];
    assign tag      = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign req      = bus.proc_read | bus.proc_write;
    assign hit      = valid[idx] && (tag_mem[idx] == tag);
    assign rd_word  = data_mem[idx][DATA_W*off +: DATA_W];
    assign read_hit = (state == IDLE) && bus.proc_read && !bus.proc_write && hit;

    assign bus.proc_stall = (state != IDLE) || (req && !hit);
    assign bus.proc_rdata = read_hit ? rd_word : rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // Each memory state spends its first cycle loading the request registers, so the
    // handshake outputs are glitch-free flops held until mem_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            miss_idx    <= '0;
            miss_tag    <= '0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (bus.proc_write) begin
                            data_mem[idx][DATA_W*off +: DATA_W] <= bus.proc_wdata;
                            dirty[idx] <= 1'b1;
                        end else begin
                            rdata_q <= rd_word;
                        end
                    end else if (req) begin
                        miss_idx <= idx;
                        miss_tag <= tag;
                        state    <= (valid[idx] && dirty[idx]) ? WBACK : ALLOC;
                    end
                end
                WBACK: begin
                    if (!mem_write_q) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_mem[miss_idx], miss_idx};
                        mem_wdata_q <= data_mem[miss_idx];
                    end else if (bus.mem_ready) begin
                        mem_write_q     <= 1'b0;
                        dirty[miss_idx] <= 1'b0;
                        state           <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (!mem_read_q) begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= {miss_tag, miss_idx};
                    end else if (bus.mem_ready) begin
                        mem_read_q         <= 1'b0;
                        data_mem[miss_idx] <= bus.mem_rdata;
                        tag_mem[miss_idx]  <= miss_tag;
                        valid[miss_idx]    <= 1'b1;
                        dirty[miss_idx]    <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STAT_EN
    logic refill;

    // The hit that retires a just-filled miss belongs to that miss, so refill masks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                refill <= 1'b0;
            end
            if (state == ALLOC && mem_read_q && bus.mem_ready) begin
                refill <= 1'b1;
            end
            if (state == IDLE && req && hit && !refill && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (state == IDLE && req && !hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
